timer_bank: RTL and testbench
=============================

Name: timer_bank

Overview:
Parametrised multi-channel programmable timer. It is the successor to the single-enable, single-trigger timer in the SoC top level. NUM_CH independent down-counters share one prescaler. Each channel runs in one-shot, periodic or cascade mode and has a sticky interrupt flag. It sits beside the CPU, memory and UART and is configured through a simple write strobe.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
CNT_W, 16, counter and reload width in bits
PRESCALE_W, 8, prescaler compare width in bits
CH_W (localparam), max(1, clog2(NUM_CH)), channel index width

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
prescale  in  PRESCALE_W  a tick occurs every prescale+1 clocks
cfg_we  in  1  write strobe for the channel configuration
cfg_ch  in  CH_W  channel addressed by cfg_we
cfg_load  in  CNT_W  reload value
cfg_mode  in  2  00 one-shot, 01 periodic, 10 cascade, 11 treated as one-shot
ch_enable  in  NUM_CH  per-channel run enable (level)
irq_clear  in  NUM_CH  per-channel interrupt clear strobe
rd_ch  in  CH_W  channel selected for readback
rd_count  out  CNT_W  current count of rd_ch (combinational mux)
timer_trigger  out  NUM_CH  one-cycle registered expiry pulse
irq_pending  out  NUM_CH  sticky expiry flag

Behaviour:
- Reset (synchronous, high):
  - pre_cnt=0; every channel: count=0, load=0, mode=00, state IDLE.
  - timer_trigger=0, irq_pending=0. rd_count therefore reads 0.
- Prescaler:
  - pre_cnt increments every clock and free-runs out of reset.
  - tick=1 when pre_cnt>=prescale; pre_cnt wraps to 0 on the same edge.
  - prescale=0 gives a tick every cycle. Comparing with >= makes a mid-count reduction of prescale take effect immediately.
- Channel event source:
  - Modes 00 and 01 use tick.
  - Mode 10 uses the registered timer_trigger[k-1]. Channel 0 in mode 10 behaves as periodic on tick.
- Channel FSM, states IDLE / RUN / DONE:
  - IDLE -> RUN when ch_enable=1.
  - RUN -> IDLE when ch_enable=0. The count is held (pause) and resumes unchanged on re-enable.
  - In RUN, on each event:
    - count!=0: count decrements by 1.
    - count==0: timer_trigger[k] is 1 on the next cycle only, and count reloads from load.
    - Mode 00 then goes to DONE. Modes 01 and 10 stay in RUN.
  - Expiry period is load+1 events; load=0 expires on every event.
  - DONE: no counting. DONE -> IDLE when ch_enable=0. A later enable restarts from the reloaded count.
- Configuration write (cfg_we=1, cfg_ch<NUM_CH):
  - Writes load and mode, sets count=cfg_load and state IDLE on the next edge.
  - If ch_enable stays 1, the channel re-enters RUN one cycle later.
  - cfg_ch>=NUM_CH: write ignored. rd_ch>=NUM_CH: rd_count=0.
- Simultaneous events:
  - cfg_we on the same cycle as an expiry on that channel: cfg wins, no trigger.
  - irq_clear and a set on the same cycle: set wins, flag stays 1.
  - reset dominates every other input.
- irq_pending[k] is set on the cycle timer_trigger[k] is 1 and cleared by irq_clear[k].
- Cascade latency: one extra clock per stage, because the source is the registered trigger.
- Width rules: all counter arithmetic is unsigned CNT_W bits. Decrement never underflows because zero takes the reload path.

Decomposition:
- Package timer_bank_pkg:
  - Mode constants MODE_ONESHOT, MODE_PERIODIC, MODE_CASCADE.
  - Channel state enum: IDLE, RUN, DONE.
- Sub-module timer_channel: one counter, FSM and irq flag. Generated NUM_CH times.
- Top-level timer_bank: prescaler, cascade wiring, cfg decode, readback mux.

Test Plan:
All scenarios use NUM_CH=4, CNT_W=16.
1. prescale=0, write ch0 load=3 mode=00, then ch_enable[0]=1 -> timer_trigger[0] is a single 1-cycle pulse 5 edges after enable is first sampled. Then DONE, no further pulses; irq_pending[0]=1 until irq_clear[0].
2. prescale=1, ch1 load=2 mode=01 -> timer_trigger[1] pulses every 6 clocks, 5+ consecutive pulses; rd_ch=1 shows 2,2,1,1,0,0 pattern.
3. prescale=0, ch0 load=1 mode=01, ch1 load=2 mode=10 -> ch0 pulses every 2 clocks. ch1 pulses once per 3 ch0 pulses, one clock after every third ch0 pulse.
4. Pause / flag collision:
   - ch2 load=100 periodic; drop ch_enable[2] at count=40 for 10 cycles -> rd_count holds 40 and resumes 39.
   - irq_clear[2] asserted on a trigger cycle -> irq_pending[2] stays 1.
5. Write collision: cfg_we to ch0 with load=7 on the exact cycle ch0 would expire -> no trigger; count=7, state IDLE, RUN next cycle.
6. reset for 1 cycle mid-RUN with count=5 -> next edge all counts 0, timer_trigger=0, irq_pending=0; no trigger until reconfigured and enabled.

Source files
------------

// File: rtl/timer_bank_pkg.sv
// Shared constants and types for the multi-channel timer bank.
// Mode encodings, channel FSM states and the channel-index width helper.
package timer_bank_pkg;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_CASCADE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ch_state_e;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reloadable down-counter, IDLE/RUN/DONE FSM, expiry pulse
// and sticky interrupt flag.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             cascade_ev,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_load,
    input  logic [1:0]       cfg_mode,
    input  logic             irq_clear,
    output logic [CNT_W-1:0] count,
    output logic             trigger,
    output logic             irq_pending
);

    ch_state_e        state, state_n;
    logic [CNT_W-1:0] load, load_n, count_n;
    logic [1:0]       mode, mode_n;
    logic             trig_n, irq_n;
    logic             ev, oneshot;

    assign ev      = (mode == MODE_CASCADE) ? cascade_ev : tick;
    assign oneshot = (mode != MODE_PERIODIC) && (mode != MODE_CASCADE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            load        <= '0;
            mode        <= MODE_ONESHOT;
            trigger     <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            load        <= load_n;
            mode        <= mode_n;
            trigger     <= trig_n;
            irq_pending <= irq_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        load_n  = load;
        mode_n  = mode;
        trig_n  = 1'b0;

        if (cfg_we) begin
            load_n  = cfg_load;
            mode_n  = cfg_mode;
            count_n = cfg_load;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (enable) state_n = RUN;
                RUN: begin
                    if (!enable) begin
                        state_n = IDLE;
                    end else if (ev) begin
                        if (count != '0) begin
                            count_n = count - 1'b1;
                        end else begin
                            trig_n  = 1'b1;
                            count_n = load;
                            if (oneshot) state_n = DONE;
                        end
                    end
                end
                DONE: if (!enable) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end

        // A clear is ignored both on the edge that raises the pulse and
        // while the pulse is visible, so a clear racing an expiry never loses it.
        irq_n = trig_n | trigger | (irq_pending & ~irq_clear);
    end

endmodule

// File: rtl/timer_bank.sv
// Multi-channel programmable timer: shared prescaler, cascade chaining,
// configuration decode and count readback around NUM_CH timer_channel instances.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int CNT_W      = 16,
    parameter  int PRESCALE_W = 8,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [CNT_W-1:0]      cfg_load,
    input  logic [1:0]            cfg_mode,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic [NUM_CH-1:0]     irq_clear,
    input  logic [CH_W-1:0]       rd_ch,
    output logic [CNT_W-1:0]      rd_count,
    output logic [NUM_CH-1:0]     timer_trigger,
    output logic [NUM_CH-1:0]     irq_pending
);

    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  tick;
    logic [CNT_W-1:0]      counts [NUM_CH];

    // >= rather than == so lowering prescale mid-count takes effect at once.
    assign tick = (pre_cnt >= prescale);

    always_ff @(posedge clk) begin
        if (reset || tick) pre_cnt <= '0;
        else               pre_cnt <= pre_cnt + 1'b1;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic ev_src;
        logic we;

        if (k == 0) begin : g_first
            assign ev_src = tick;
        end else begin : g_chain
            assign ev_src = timer_trigger[k-1];
        end

        // Indices at or above NUM_CH match no channel, so such writes drop.
        assign we = cfg_we && (cfg_ch == CH_W'(k));

        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .cascade_ev (ev_src),
            .enable     (ch_enable[k]),
            .cfg_we     (we),
            .cfg_load   (cfg_load),
            .cfg_mode   (cfg_mode),
            .irq_clear  (irq_clear[k]),
            .count      (counts[k]),
            .trigger    (timer_trigger[k]),
            .irq_pending(irq_pending[k])
        );
    end

    always_comb begin
        rd_count = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (rd_ch == CH_W'(k)) rd_count = counts[k];
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: table-driven one-shot sequence, a trigger
// scoreboard for periodic/cascade runs, and hand-written corner sequences.
module tb_timer_bank;
    import timer_bank_pkg::*;

    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 16;
    localparam int PRESCALE_W = 8;
    localparam int CH_W       = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [PRESCALE_W-1:0] prescale;
    logic                  cfg_we;
    logic [CH_W-1:0]       cfg_ch;
    logic [CNT_W-1:0]      cfg_load;
    logic [1:0]            cfg_mode;
    logic [NUM_CH-1:0]     ch_enable;
    logic [NUM_CH-1:0]     irq_clear;
    logic [CH_W-1:0]       rd_ch;
    logic [CNT_W-1:0]      rd_count;
    logic [NUM_CH-1:0]     timer_trigger;
    logic [NUM_CH-1:0]     irq_pending;

    timer_bank #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .PRESCALE_W(PRESCALE_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .prescale     (prescale),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_load     (cfg_load),
        .cfg_mode     (cfg_mode),
        .ch_enable    (ch_enable),
        .irq_clear    (irq_clear),
        .rd_ch        (rd_ch),
        .rd_count     (rd_count),
        .timer_trigger(timer_trigger),
        .irq_pending  (irq_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int base   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [PRESCALE_W-1:0] ps);
        reset     = 1'b1;
        prescale  = ps;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_load  = '0;
        cfg_mode  = 2'b00;
        ch_enable = '0;
        irq_clear = '0;
        rd_ch     = '0;
        step(1);
        reset = 1'b0;
        base  = cyc;
    endtask

    task automatic cfg(input int ch, input int ld, input logic [1:0] md);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_load = CNT_W'(ld);
        cfg_mode = md;
        step(1);
        cfg_we = 1'b0;
    endtask

    // Trigger scoreboard: expected pulses queued ahead of time, checked per cycle.
    typedef struct {
        int                cyc;
        logic [NUM_CH-1:0] trig;
    } sb_item_t;

    sb_item_t          sb[$];
    int                mon_lo   = 1;
    int                mon_hi   = 0;
    logic [NUM_CH-1:0] mon_mask = '0;

    always @(posedge clk) begin
        sb_item_t it;
        #1;
        if (cyc >= mon_lo && cyc <= mon_hi) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                it = sb.pop_front();
                check("sb_trigger", 32'(timer_trigger & mon_mask), 32'(it.trig));
            end else begin
                check("sb_quiet", 32'(timer_trigger & mon_mask), 32'd0);
            end
        end
    end

    typedef struct {
        logic        en;
        logic        clr;
        logic [15:0] cnt;
        logic        trig;
        logic        irq;
    } vec_t;

    vec_t tbl[11];
    int   pat[6];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 16'd3, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'd2, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'd3, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 16'd3, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 16'd3, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 16'd3, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 16'd3, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 16'd3, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 16'd2, 1'b0, 1'b0};
        pat = '{2, 2, 1, 1, 0, 0};

        // Reset state
        do_reset(8'd0);
        check("reset_count", 32'(rd_count), 32'd0);
        check("reset_trig", 32'(timer_trigger), 32'd0);
        check("reset_irq", 32'(irq_pending), 32'd0);

        // One-shot, load=3, prescale=0
        cfg(0, 3, MODE_ONESHOT);
        for (int i = 0; i < 11; i++) begin
            ch_enable[0] = tbl[i].en;
            irq_clear[0] = tbl[i].clr;
            step(1);
            check($sformatf("t1_count[%0d]", i), 32'(rd_count), 32'(tbl[i].cnt));
            check($sformatf("t1_trig[%0d]", i), 32'(timer_trigger[0]), 32'(tbl[i].trig));
            check($sformatf("t1_irq[%0d]", i), 32'(irq_pending[0]), 32'(tbl[i].irq));
        end
        irq_clear = '0;

        // Periodic ch1, load=2, prescale=1: pulse every 6 clocks
        do_reset(8'd1);
        for (int i = 0; i < 5; i++) sb.push_back('{base + 8 + 6 * i, 4'b0010});
        mon_mask = 4'b0010;
        mon_lo   = base + 1;
        mon_hi   = base + 34;
        cfg(1, 2, MODE_PERIODIC);
        ch_enable = 4'b0010;
        rd_ch     = 2'd1;
        step(7);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t2_count[%0d]", i), 32'(rd_count), 32'(pat[i % 6]));
            step(1);
        end
        step(15);
        check("t2_sb_drained", 32'(sb.size()), 32'd0);

        // Cascade: ch0 periodic load=1, ch1 cascade load=2
        do_reset(8'd0);
        for (int c = 3; c <= 22; c++) begin
            logic [NUM_CH-1:0] e;
            e    = '0;
            e[0] = (c >= 5) && ((c - 5) % 2 == 0);
            e[1] = (c >= 10) && ((c - 10) % 6 == 0);
            if (e != '0) sb.push_back('{base + c, e});
        end
        mon_mask = 4'b0011;
        mon_lo   = base + 3;
        mon_hi   = base + 22;
        cfg(0, 1, MODE_PERIODIC);
        cfg(1, 2, MODE_CASCADE);
        ch_enable = 4'b0011;
        step(21);
        check("t3_sb_drained", 32'(sb.size()), 32'd0);

        // Pause/resume and irq clear colliding with a trigger
        do_reset(8'd0);
        cfg(2, 100, MODE_PERIODIC);
        ch_enable = 4'b0100;
        rd_ch     = 2'd2;
        step(61);
        check("t4_at40", 32'(rd_count), 32'd40);
        ch_enable = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check($sformatf("t4_hold[%0d]", i), 32'(rd_count), 32'd40);
        end
        ch_enable = 4'b0100;
        step(1);
        check("t4_rerun", 32'(rd_count), 32'd40);
        step(1);
        check("t4_resume", 32'(rd_count), 32'd39);
        step(40);
        check("t4_trig", 32'(timer_trigger[2]), 32'd1);
        check("t4_irq_set", 32'(irq_pending[2]), 32'd1);
        irq_clear = 4'b0100;
        step(1);
        check("t4_irq_kept", 32'(irq_pending[2]), 32'd1);
        step(1);
        check("t4_irq_cleared", 32'(irq_pending[2]), 32'd0);
        irq_clear = '0;

        // Config write on the expiry cycle wins
        do_reset(8'd0);
        cfg(0, 2, MODE_PERIODIC);
        ch_enable = 4'b0001;
        step(3);
        check("t5_at0", 32'(rd_count), 32'd0);
        cfg(0, 7, MODE_PERIODIC);
        check("t5_no_trig", 32'(timer_trigger[0]), 32'd0);
        check("t5_reload", 32'(rd_count), 32'd7);
        check("t5_no_irq", 32'(irq_pending[0]), 32'd0);
        step(1);
        check("t5_idle_hold", 32'(rd_count), 32'd7);
        step(1);
        check("t5_run", 32'(rd_count), 32'd6);

        // Reset mid-run
        do_reset(8'd0);
        cfg(0, 8, MODE_ONESHOT);
        ch_enable = 4'b0001;
        cfg(1, 0, MODE_PERIODIC);
        ch_enable = 4'b0011;
        step(3);
        check("t6_count5", 32'(rd_count), 32'd5);
        check("t6_irq1_pre", 32'(irq_pending[1]), 32'd1);
        reset     = 1'b1;
        ch_enable = '0;
        step(1);
        reset = 1'b0;
        check("t6_count0", 32'(rd_count), 32'd0);
        rd_ch = 2'd1;
        #1;
        check("t6_count1", 32'(rd_count), 32'd0);
        check("t6_trig", 32'(timer_trigger), 32'd0);
        check("t6_irq", 32'(irq_pending), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check($sformatf("t6_quiet[%0d]", i), 32'(timer_trigger), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
